// File: rtl/ps_arbiter.sv
// Round-robin arbiter sharing one ps_if slave among several ps_if masters.
// Whole write or read transactions are serialised; one idle cycle separates grants.
module ps_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_waddr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]            m_wvalid,
    output logic [NUM_MASTERS-1:0]            m_wready,
    output logic [NUM_MASTERS-1:0]            m_wresp,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_raddr,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    output logic [ADDR_WIDTH-1:0]             s_waddr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic                              s_wvalid,
    input  logic                              s_wready,
    input  logic                              s_wresp,
    output logic [ADDR_WIDTH-1:0]             s_raddr,
    output logic                              s_arvalid,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [PW-1:0]           gidx_q, gidx_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           pick, nxt_ptr;
    logic                    pick_vld;
    logic [PW:0]             cand;
    logic [NUM_MASTERS-1:0]  req;
    logic [ADDR_WIDTH-1:0]   raddr_q;

    assign req = m_wvalid | m_arvalid;

    // First requester at or after ptr_q, modulo NUM_MASTERS.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_MASTERS))
                cand = cand - (PW+1)'(NUM_MASTERS);
            if (!pick_vld && req[cand[PW-1:0]]) begin
                pick     = cand[PW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign nxt_ptr = (gidx_q == PW'(NUM_MASTERS-1)) ? '0
                                                     : gidx_q + PW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = m_wvalid[pick] ? WR : RD_ADDR;
                    grant_d = NUM_MASTERS'(1) << pick;
                    gidx_d  = pick;
                end
            end
            WR: begin
                // An abandoned write releases the slave but keeps the pointer.
                if (!m_wvalid[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (s_wready) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                if (s_rvalid && m_rready[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            if (state_q == RD_ADDR)
                raddr_q <= m_raddr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        s_waddr   = '0;
        s_wdata   = '0;
        s_wvalid  = 1'b0;
        s_raddr   = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_wready  = '0;
        m_wresp   = '0;
        m_rvalid  = '0;
        unique case (state_q)
            WR: begin
                s_waddr  = m_waddr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
                s_wdata  = m_wdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
                s_wvalid = m_wvalid[gidx_q];
                m_wready = grant_q & {NUM_MASTERS{s_wready}};
                m_wresp  = grant_q & {NUM_MASTERS{s_wresp}};
            end
            RD_ADDR: begin
                s_raddr   = m_raddr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
                s_arvalid = 1'b1;
            end
            RD_DATA: begin
                s_raddr  = raddr_q;
                s_rready = m_rready[gidx_q];
                m_rvalid = grant_q & {NUM_MASTERS{s_rvalid}};
            end
            default: ;
        endcase
    end

    assign m_rdata = {NUM_MASTERS{s_rdata}};
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);

endmodule
